// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared pipeline defines: stall encodings, bus width, stage indices, NOP payload
package pipe_stage_reg_pkg;

    // Per-stage stall encoding on the stall bus
    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    // Stall bus width and the stage index of each pipeline register's upstream stage
    localparam int STALL_W   = 6;
    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;
    localparam int STAGE_WB  = 5;

    // Default payload loaded on reset, flush and bubble
    localparam int                 NOP_W   = 160;
    localparam logic [NOP_W-1:0]   NOP_DEF = '0;

    // Action taken by a pipeline register on a given edge (reset handled separately)
    typedef enum logic [1:0] {
        ACT_FLUSH   = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_ADVANCE = 2'd2,
        ACT_HOLD    = 2'd3
    } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating hold-age counter with registered saturate flag
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   clr, inc      clear (wins) / increment request
//   count         current count, saturates at all-ones
//   stuck         1 exactly when count is all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && (count != CNT_MAX)) begin
            count_nxt = count + CNT_ONE;
        end
    end

    // stuck is derived from the next value so it updates on the same edge as count
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            stuck <= 1'b0;
        end else begin
            count <= count_nxt;
            stuck <= (count_nxt == CNT_MAX);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline register with stall/bubble/flush control and stall-age tracking
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   stall[STALL_W]               per-stage stall bus (STOP/NOT_STOP)
//   flush                        exception flush, discards the entry
//   in_valid/in_data/in_side/in_dbg    upstream slot contents
//   out_valid/out_data/out_side/out_dbg registered slot contents (out_side feeds back upstream)
//   hold_age, hold_stuck         consecutive hold cycles of the valid entry, saturated flag
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 160,
    parameter int                SIDE_W  = 66,
    parameter int                DBG_W   = 32,
    parameter int                STALL_W = pipe_stage_reg_pkg::STALL_W,
    parameter int                STAGE   = STAGE_EX,
    parameter int                CNT_W   = 8,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SIDE_W-1:0]  in_side,
    input  logic [DBG_W-1:0]   in_dbg,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [SIDE_W-1:0]  out_side,
    output logic [DBG_W-1:0]   out_dbg,
    output logic [CNT_W-1:0]   hold_age,
    output logic               hold_stuck
);

    logic       up;
    logic       dn;
    logic       unused_stall;
    logic       hold_valid;
    stage_act_e act;

    assign up = stall[STAGE];

    // The last stage has no downstream stage, so it can never be held from below
    generate
        if (STAGE == STALL_W - 1) begin : g_top_stage
            assign dn = NOT_STOP;
        end else begin : g_mid_stage
            assign dn = stall[STAGE+1];
        end
    endgenerate

    // Only two bits of the stall bus are meaningful to any one register
    assign unused_stall = ^stall;

    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if ((up == STOP) && (dn == NOT_STOP)) begin
            act = ACT_BUBBLE;
        end else if (up == NOT_STOP) begin
            act = ACT_ADVANCE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= NOP_VAL;
            out_side  <= '0;
            out_dbg   <= '0;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    out_valid <= 1'b0;
                    out_data  <= NOP_VAL;
                    out_side  <= '0;
                    out_dbg   <= '0;
                end
                // Bubble keeps the upstream side-state circulating so a multicycle op can finish
                ACT_BUBBLE: begin
                    out_valid <= 1'b0;
                    out_data  <= NOP_VAL;
                    out_side  <= in_side;
                    out_dbg   <= in_dbg;
                end
                ACT_ADVANCE: begin
                    out_valid <= in_valid;
                    out_data  <= in_data;
                    out_side  <= '0;
                    out_dbg   <= in_dbg;
                end
                default: begin
                    out_side  <= in_side;
                end
            endcase
        end
    end

    // Age only grows while a real entry is held; every other case restarts it
    assign hold_valid = (act == ACT_HOLD) && out_valid;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hold_age (
        .clk   (clk),
        .rst   (rst),
        .clr   (!hold_valid),
        .inc   (hold_valid),
        .count (hold_age),
        .stuck (hold_stuck)
    );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 160: width of the main payload forwarded to the next stage.
REQ-002 Parameter SIDE_W, default 66: width of the multicycle side-state (e.g. 2-bit cycle count plus 64-bit partial product).
REQ-003 Parameter DBG_W, default 32: width of the debug field (instruction word).
REQ-004 Parameter STALL_W, default 6: width of the pipeline stall bus.
REQ-005 Parameter STAGE, default 3: index of this register's upstream stage in the stall bus; legal range 0..STALL_W-1.
REQ-006 Parameter CNT_W, default 8: width of the stall-age counter.
REQ-007 Parameter NOP_VAL, default all-zero DATA_W: payload loaded on reset, flush and bubble.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-010 stall  input  STALL_W  per-stage stall, 1 = Stop, 0 = NotStop.
REQ-011 flush  input  1  exception flush, 1 = discard.
REQ-012 in_valid  input  1  upstream slot holds a real instruction.
REQ-013 in_data  input  DATA_W  upstream payload.
REQ-014 in_side  input  SIDE_W  upstream multicycle side-state.
REQ-015 in_dbg  input  DBG_W  upstream debug field.
REQ-016 out_valid  output  1  registered valid.
REQ-017 out_data  output  DATA_W  registered payload.
REQ-018 out_side  output  SIDE_W  registered side-state, fed back upstream.
REQ-019 out_dbg  output  DBG_W  registered debug field.
REQ-020 hold_age  output  CNT_W  consecutive hold cycles of the current valid entry.
REQ-021 hold_stuck  output  1  hold_age saturated at all-ones.

Function
REQ-022 Define up = stall[STAGE] and dn = stall[STAGE+1]; dn is 0 when STAGE = STALL_W-1.
REQ-023 Per-edge priority: reset > flush > bubble (up=1, dn=0) > advance (up=0) > hold (up=1, dn=1).
REQ-024 Flush: out_valid<=0, out_data<=NOP_VAL, out_side<=0, out_dbg<=0, hold_age<=0.
REQ-025 Bubble: out_valid<=0, out_data<=NOP_VAL, out_dbg<=in_dbg, out_side<=in_side, hold_age<=0.
REQ-026 Advance: out_valid<=in_valid, out_data<=in_data, out_dbg<=in_dbg, out_side<=0, hold_age<=0.
REQ-027 Hold: out_valid, out_data and out_dbg retain their values; out_side<=in_side.
REQ-028 Hold with out_valid=1: hold_age increments by 1 and saturates at 2^CNT_W-1. With out_valid=0 it stays 0.
REQ-029 hold_stuck is 1 exactly when hold_age equals 2^CNT_W-1; it is registered together with hold_age.
REQ-030 Latency is one cycle on advance; there is no combinational path from any input to any output.
REQ-031 Flush asserted together with any stall pattern takes the flush action (REQ-024).
REQ-032 in_side is sampled only on bubble and hold; it is ignored on advance and flush.

Reset
REQ-033 When rst=0 at a rising edge, all outputs take the flush values (REQ-024) and hold_stuck<=0, regardless of stall and flush.
REQ-034 Reset asserted mid-hold or mid-multicycle clears the side-state; the entry is not retained.

Structure
REQ-035 Stop/NotStop encodings, the stall-bus width and the default NOP payload live in the shared defines package. STAGE indices for IF/ID/EX/MEM/WB also live there.
REQ-036 Single flat module; one optional sub-module, sat_counter (CNT_W-bit, increment/clear, saturate flag), implements hold_age and hold_stuck.
REQ-037 The new EX/MEM instance sets STAGE=3 and packs its fields into in_data; other pipeline registers set their own STAGE value.

Verification
REQ-038 Advance: rst=1, stall=0, in_valid=1, in_data=0xA5..., next edge -> out_valid=1, out_data=0xA5..., out_side=0.
REQ-039 Bubble: stall=6'b001000, in_side=66'h2_0000_0001_0000_0002, in_dbg=0x1234 -> out_valid=0, out_data=NOP_VAL, out_side=in_side, out_dbg=0x1234.
REQ-040 Hold: stall=6'b011000 for 3 edges after a valid load -> payload unchanged, hold_age=3. Then stall=0 -> hold_age=0 and the new payload is taken.
REQ-041 Saturation: CNT_W=2, hold for 5 edges -> hold_age=3, hold_stuck=1 from the 3rd edge on.
REQ-042 Priority: flush=1 with stall=6'b001000 -> flush values. rst=0 with flush=1 -> reset values.
REQ-043 Top stage: STAGE=5, stall=6'b100000 -> bubble action (dn treated as 0).
